// File: rtl/sobel_line_buffer_if.sv
// Pixel stream in, three-row column bundle out.
// Master drives pixels; slave is the line buffer.
interface sobel_line_buffer_if #(
    parameter int DW = 8
);
    logic [DW-1:0] d_i;
    logic          done_i;
    logic [DW-1:0] d0_o;
    logic [DW-1:0] d1_o;
    logic [DW-1:0] d2_o;
    logic          done_o;
    logic          eol_o;
    logic          eof_o;

    modport master (
        output d_i, done_i,
        input  d0_o, d1_o, d2_o, done_o, eol_o, eof_o
    );

    modport slave (
        input  d_i, done_i,
        output d0_o, d1_o, d2_o, done_o, eol_o, eof_o
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer producing column-aligned
// top/middle/current pixel triples for a Sobel stage.
module sobel_line_buffer #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input logic                clk,
    input logic                rst,
    sobel_line_buffer_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {
        FILL,
        STREAM
    } state_t;

    state_t        state_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          last_col;
    logic          last_row;
    logic          acc;

    logic [DW-1:0] lb_a [IMG_W];
    logic [DW-1:0] lb_b [IMG_W];
    logic [DW-1:0] a_rd, b_rd;

    logic [DW-1:0] d0_q, d1_q, d2_q;
    logic          done_q, eol_q, eof_q;

    assign acc  = bus.done_i;
    assign a_rd = lb_a[col_q];
    assign b_rd = lb_b[col_q];

    // Raster position bookkeeping for the next accepted pixel.
    always_comb begin
        last_col = (col_q == CW'(IMG_W - 1));
        last_row = (row_q == RW'(IMG_H - 1));
        col_d    = col_q + CW'(1);
        row_d    = row_q;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
        end
    end

    // Shift the column down one row: A moves to B, new pixel into A.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_b[col_q] <= a_rd;
            lb_a[col_q] <= bus.d_i;
        end
    end

    // Fill/stream control with registered outputs and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            done_q  <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            eol_q  <= 1'b0;
            eof_q  <= 1'b0;
            if (acc) begin
                col_q <= col_d;
                row_q <= row_d;
                d0_q  <= b_rd;
                d1_q  <= a_rd;
                d2_q  <= bus.d_i;
                unique case (state_q)
                    FILL: begin
                        if (last_col && row_q == RW'(1))
                            state_q <= STREAM;
                    end
                    STREAM: begin
                        done_q <= 1'b1;
                        eol_q  <= last_col;
                        eof_q  <= last_col && last_row;
                        if (last_col && last_row)
                            state_q <= FILL;
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign bus.d0_o   = d0_q;
    assign bus.d1_o   = d1_q;
    assign bus.d2_o   = d2_q;
    assign bus.done_o = done_q;
    assign bus.eol_o  = eol_q;
    assign bus.eof_o  = eof_q;
endmodule
